mult_unit: RTL
==============

// Module: mult_unit
// PURPOSE
//  Iterative shift-add HI/LO multiplier executing MIPS mult/multu.
//  Consumes start_mult/mult_sign from the decode controller and rs/rt operands.
//  Produces the 64-bit product in hi/lo registers, which the writeback mux
//  reads for mfhi/mflo.
//  busy drives the hazard unit so that mfhi/mflo stall until the product is valid.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH (hi = upper WIDTH, lo = lower WIDTH)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous reset, active low
//  start_mult  in   1      request new multiply; sampled only in IDLE
//  mult_sign   in   1      1 = signed (mult), 0 = unsigned (multu); sampled with start
//  a           in   WIDTH  multiplicand (rs); sampled with start
//  b           in   WIDTH  multiplier (rt); sampled with start
//  hi          out  WIDTH  upper product half (HI register)
//  lo          out  WIDTH  lower product half (LO register)
//  busy        out  1      multiply in progress (state != IDLE)
//  done        out  1      one-cycle pulse: hi/lo were just updated
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0;
//   internal accumulator, operand and count registers cleared.
//  Single clock domain; one clock, no other edges.
//  FSM: IDLE -> RUN -> FINISH -> IDLE.
//  IDLE:
//   - At an edge with start_mult=1: latch |a|, |b| (two's-complement magnitude
//     when mult_sign=1, raw otherwise), neg = mult_sign & (a[W-1]^b[W-1]).
//   - Clear the 2W-bit accumulator; count=0; go to RUN.
//   - start_mult=0: stay in IDLE; hi/lo hold.
//  RUN, one iteration per edge:
//   - If multiplier LSB=1, acc += multiplicand shifted by count.
//     Equivalent right-shift formulation is acceptable.
//   - Shift the multiplier right by 1; count++.
//   - After WIDTH iterations (count reaches WIDTH-1 this edge), go to FINISH.
//  FINISH:
//   - At the next edge, {hi,lo} <= neg ? -acc : acc (2W-bit two's complement).
//   - done=1 for the following cycle; go to IDLE.
//  Latency:
//   - Start sampled at edge E0; RUN occupies E1..E_WIDTH; hi/lo update at E_(WIDTH+1).
//   - New values are visible WIDTH+1 cycles after E0.
//   - busy=1 from after E0 through the cycle before E_(WIDTH+1) deasserts it.
//  hi/lo hold previous result for the entire operation; never partially updated.
//  start_mult while busy=1: ignored, no queueing. Controller/hazard unit must stall.
//  start_mult in the done cycle: accepted (state is IDLE); done still pulses once.
//  a/b/mult_sign changes after E0: no effect on the running operation.
//  Magnitude of most-negative value (0x80000000): held as unsigned 0x80000000,
//   so -2^31 * -2^31 = +2^62 is exact. No overflow is possible in 2W bits.
//  Zero operand: normal full-length run; result 0, neg-correction yields 0.
//  Reset mid-operation: immediate abort to IDLE; hi/lo=0; no done pulse.
//  No combinational path from inputs to outputs; all outputs registered or
//   decoded from state.
// TESTING
//  1. multu a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE lo=0x00000001,
//     done pulses 1 cycle, busy high 33 cycles.
//  2. mult a=0xFFFFFFFD(-3) b=0x00000005 -> hi=0xFFFFFFFF lo=0xFFFFFFF1;
//     mult -1*-1 -> hi=0 lo=1.
//  3. mult a=b=0x80000000 -> hi=0x40000000 lo=0x00000000;
//     multu same -> hi=0x40000000 lo=0.
//  4. Second start_mult pulsed mid-RUN with different operands -> ignored;
//     first result delivered, single done.
//  5. start_mult asserted in done cycle (7*6 then 0*9) -> hi/lo=0:42 then 0:0,
//     two done pulses 34 cycles apart.
//  6. rst_n low for 1 cycle at RUN iteration 10 -> hi=lo=0, busy=0, no done;
//     a fresh 2*3 then completes to lo=6.

Source files
------------

// File: rtl/mult_unit.sv
// Iterative shift-add HI/LO multiplier for MIPS mult/multu.
// One partial product per cycle; hi/lo only change on completion.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;
    logic               r_neg;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_sum;
    logic [2*WIDTH-1:0] w_prod;

    // Magnitudes; -MIN wraps to itself, which reads correctly as unsigned
    assign w_mag_a = (mult_sign & a[WIDTH-1]) ? -a : a;
    assign w_mag_b = (mult_sign & b[WIDTH-1]) ? -b : b;
    assign w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod  = r_neg ? -r_acc : r_acc;

    // Control FSM, datapath iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_mult) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= mult_sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    {r_hi, r_lo} <= w_prod;
                    r_done       <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;
    assign busy = (r_state != S_IDLE);

endmodule
